// File: rtl/puf_challenge_sequencer_if.sv
// Handshake bundle between a challenge producer / result consumer and the
// PUF challenge sequencer. The sequencer takes the slave view. The producer
// or consumer takes the master view.
interface puf_challenge_sequencer_if #(
    parameter int CW = 16
);
    logic          chal_valid;
    logic          chal_ready;
    logic [CW-1:0] chal_in;
    logic          resp_valid;
    logic          resp_ready;
    logic [CW-1:0] resp_data;
    logic [CW-1:0] resp_chal;
    logic [CW-1:0] unstable;

    modport master (
        output chal_valid,
        output chal_in,
        output resp_ready,
        input  chal_ready,
        input  resp_valid,
        input  resp_data,
        input  resp_chal,
        input  unstable
    );

    modport slave (
        input  chal_valid,
        input  chal_in,
        input  resp_ready,
        output chal_ready,
        output resp_valid,
        output resp_data,
        output resp_chal,
        output unstable
    );
endinterface

// File: rtl/puf_challenge_sequencer.sv
// Drives one challenge into the arbiter PUF array and fires REPEATS
// precharge/evaluate cycles. It samples the synchronised response after each
// evaluation and returns a per-bit majority vote with an instability mask.
module puf_challenge_sequencer #(
    parameter int CW         = 16,
    parameter int REPEATS    = 5,
    parameter int SETTLE_CYC = 4,
    parameter int EVAL_CYC   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    puf_challenge_sequencer_if.slave bus,
    output logic                    puf_pulse,
    output logic [CW-1:0]           puf_challenge,
    input  logic [CW-1:0]           puf_response,
    output logic                    busy
);

    // Counters hold 0..REPEATS. The phase timer counts 0..phase_length-1.
    localparam int CNT_W  = $clog2(REPEATS + 1);
    localparam int PH_MAX = (SETTLE_CYC > EVAL_CYC) ? SETTLE_CYC : EVAL_CYC;
    localparam int TMR_W  = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] EVAL_LAST   = TMR_W'(EVAL_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST    = CNT_W'(REPEATS - 1);
    localparam logic [CNT_W-1:0] REP_HALF    = CNT_W'(REPEATS / 2);
    localparam logic [CNT_W-1:0] REP_FULL    = CNT_W'(REPEATS);

    typedef enum logic [2:0] {
        IDLE,
        PRECHARGE,
        FIRE,
        SAMPLE,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [TMR_W-1:0] tmr;
    logic [CNT_W-1:0] rep_cnt;
    logic [CNT_W-1:0] ones     [CW];
    logic [CNT_W-1:0] ones_sum [CW];
    logic [CW-1:0]    sync1;
    logic [CW-1:0]    sync2;
    logic [CW-1:0]    vote_vec;
    logic [CW-1:0]    mixed_vec;
    logic             accept;
    logic             last_sample;

    // A bit resolves to 1 only on a strict majority, so a tie on even REPEATS gives 0.
    function automatic logic vote(input logic [CNT_W-1:0] cnt);
        return (cnt > REP_HALF);
    endfunction

    // A bit is unstable unless every sample agreed.
    function automatic logic mixed(input logic [CNT_W-1:0] cnt);
        return (cnt != '0) && (cnt != REP_FULL);
    endfunction

    assign bus.chal_ready = rst_n && (state == IDLE);
    assign accept         = bus.chal_ready && bus.chal_valid;
    assign last_sample    = (state == SAMPLE) && (rep_cnt == REP_LAST);
    assign busy           = (state != IDLE);

    // Two-flop synchroniser for the asynchronous arbiter outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= puf_response;
            sync2 <= sync1;
        end
    end

    // Next-state selection for the precharge/fire/sample loop.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (accept) state_next = PRECHARGE;
            PRECHARGE: if (tmr == SETTLE_LAST) state_next = FIRE;
            FIRE:      if (tmr == EVAL_LAST) state_next = SAMPLE;
            SAMPLE:    state_next = (rep_cnt == REP_LAST) ? DONE : PRECHARGE;
            DONE:      if (bus.resp_ready) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // State register and phase timer. The timer restarts on every state change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            tmr   <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                tmr <= '0;
            end else if ((state == PRECHARGE) || (state == FIRE)) begin
                tmr <= tmr + 1'b1;
            end else begin
                tmr <= '0;
            end
        end
    end

    // Running ones count including the current sample, and the verdicts derived from it.
    always_comb begin
        for (int i = 0; i < CW; i++) begin
            ones_sum[i]  = ones[i] + CNT_W'(sync2[i]);
            vote_vec[i]  = vote(ones_sum[i]);
            mixed_vec[i] = mixed(ones_sum[i]);
        end
    end

    // Per-bit ones accumulators and the repeat counter. Both are cleared on each new challenge.
    always_ff @(posedge clk) begin
        if (!rst_n || accept) begin
            rep_cnt <= '0;
            for (int i = 0; i < CW; i++) ones[i] <= '0;
        end else if (state == SAMPLE) begin
            rep_cnt <= rep_cnt + 1'b1;
            for (int i = 0; i < CW; i++) ones[i] <= ones_sum[i];
        end
    end

    // Registered array drive and result capture.
    // The results are loaded on the final sample, so they stay put until the next result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            puf_pulse      <= 1'b0;
            puf_challenge  <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_data  <= '0;
            bus.resp_chal  <= '0;
            bus.unstable   <= '0;
        end else begin
            puf_pulse      <= (state_next == FIRE) || (state_next == SAMPLE);
            bus.resp_valid <= (state_next == DONE);
            if (accept) begin
                puf_challenge <= bus.chal_in;
            end
            if (last_sample) begin
                bus.resp_data <= vote_vec;
                bus.unstable  <= mixed_vec;
                bus.resp_chal <= puf_challenge;
            end
        end
    end

endmodule
